vend_lane_scheduler: RTL and testbench

- Top-level sequencer for a multi-lane vending machine.
- Accumulates coin credit in 5-unit steps and arbitrates lane selections round-robin.
- Drives a single shared dispense motor through a req/done handshake, then pays change as chg5 pulses.
- Sits between the coin-acceptor/keypad inputs and the motor driver; dispense and chg5 have the same pulse semantics as the existing vending FSM outputs.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/rr_lane_arb.sv | 68 ++++++
 rtl/vend_lane_scheduler.sv | 262 ++++++++++++++++++++++++++
 tb/tb_vend_lane_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vend_pkg                                                  |
// | Purpose  : Shared types and constants for the vending lane scheduler |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package vend_pkg;

    // Credit is tracked in 5-unit steps; 4 bits covers every legal maximum.
    localparam int CREDIT_W = 4;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CREDIT = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3,
        ST_FAULT  = 3'd4
    } vend_state_e;

    // Coin acceptor codes
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Value of a coin code in 5-unit steps (invalid / none are worth 0)
    function automatic logic [CREDIT_W-1:0] coin_steps(input logic [1:0] code);
        case (code)
            COIN_5:  return CREDIT_W'(1);
            COIN_10: return CREDIT_W'(2);
            default: return CREDIT_W'(0);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_lane_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_lane_arb                                               |
// | Purpose  : Round-robin arbiter over NLANES eligibility bits. Search  |
// |            starts at the pointer and wraps; the pointer moves to     |
// |            grant+1 when the grant is accepted.                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_lane_arb #(
    parameter int NLANES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NLANES-1:0]         elig_i,
    input  logic                      accept_i,
    output logic [$clog2(NLANES)-1:0] grant_o,
    output logic                      valid_o
);

    localparam int             IW       = $clog2(NLANES);
    localparam logic [IW:0]    c_nlanes = (IW+1)'(NLANES);
    localparam logic [IW-1:0]  c_last   = IW'(NLANES - 1);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   w_cand;
    logic [IW-1:0] w_grant;
    logic          w_found;

    // First eligible lane at or after the pointer, wrapping modulo NLANES
    always_comb begin
        w_cand  = '0;
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            w_cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (w_cand >= c_nlanes) begin
                w_cand = w_cand - c_nlanes;
            end
            if (!w_found && elig_i[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_cand[IW-1:0];
            end
        end
    end

    assign grant_o = w_grant;
    assign valid_o = w_found;

    // Pointer advances past the accepted grant only
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && w_found) begin
            ptr_d = (w_grant == c_last) ? '0 : w_grant + IW'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_lane_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vend_lane_scheduler                                       |
// | Purpose  : Multi-lane vending sequencer: coin credit, round-robin    |
// |            lane grant, shared motor req/done handshake with timeout, |
// |            change payout as chg5 pulses.                             |
// | Options  : VEND_PRESELECT_EN - latch one pending lane selected       |
// |            before enough credit, vend it once credit suffices.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module vend_lane_scheduler #(
    parameter int NLANES     = 4,
    parameter int PRICE      = 4,
    parameter int CREDIT_MAX = 7,
    parameter int STOCK_INIT = 3,
    parameter int MOTOR_TO   = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     coin_i,
    input  logic [NLANES-1:0]              sel_i,
    input  logic                           cancel_i,
    output logic                           motor_go_o,
    output logic [$clog2(NLANES)-1:0]      motor_lane_o,
    input  logic                           motor_done_i,
    output logic                           dispense_o,
    output logic                           chg5_o,
    output logic                           coin_reject_o,
    output logic                           busy_o,
    output logic                           fault_o,
    output logic [NLANES-1:0]              stock_empty_o,
    output logic [vend_pkg::CREDIT_W-1:0]  credit_o
);

    import vend_pkg::*;

    localparam int LW = $clog2(NLANES);
    localparam int SW = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);
    localparam int TW = (MOTOR_TO < 2) ? 1 : $clog2(MOTOR_TO);

    localparam logic [CREDIT_W-1:0] c_price      = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   c_credit_max = (CREDIT_W+1)'(CREDIT_MAX);
    localparam logic [TW-1:0]       c_to_last    = TW'(MOTOR_TO - 1);
    localparam logic [SW-1:0]       c_stock_init = SW'(STOCK_INIT);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                fault_q, fault_d;
    logic                motor_go_q, motor_go_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [TW-1:0]       to_q, to_d;
    logic                dispense_q, dispense_d;
    logic                chg5_q, chg5_d;
    logic                reject_q, reject_d;

    logic                stock_dec;
    logic [NLANES-1:0]   w_in_stock;
    logic                w_can_buy;
    logic [NLANES-1:0]   w_elig;
    logic [NLANES-1:0]   w_arb_elig;
    logic                w_arb_accept;
    logic [LW-1:0]       w_arb_grant;
    logic                w_arb_valid;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W:0]   w_coin_sum;

    // Per-lane stock counters; decrement only on a completed vend, saturate at 0
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        logic [SW-1:0] stock_q;

        assign w_in_stock[gi] = (stock_q != '0);

        // Stock counter for this lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stock_q <= c_stock_init;
            end else if (stock_dec && (lane_q == LW'(gi)) && w_in_stock[gi]) begin
                stock_q <= stock_q - SW'(1);
            end
        end
    end

    // Selection is judged against the credit held before any same-cycle coin
    assign w_can_buy = (credit_q >= c_price);
    assign w_elig    = sel_i & w_in_stock & {NLANES{w_can_buy}};

`ifdef VEND_PRESELECT_EN
    logic          pend_vld_q;
    logic [LW-1:0] pend_lane_q;
    logic          w_sel_hit;
    logic [LW-1:0] w_sel_low;
    logic          w_pend_fire;

    // Lowest in-stock requested lane is the candidate for the pending slot
    always_comb begin
        w_sel_hit = 1'b0;
        w_sel_low = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (sel_i[i] && w_in_stock[i]) begin
                w_sel_hit = 1'b1;
                w_sel_low = LW'(i);
            end
        end
    end

    assign w_pend_fire = (state_q == ST_CREDIT) && pend_vld_q && w_can_buy
                         && w_in_stock[pend_lane_q];
    assign w_arb_elig  = w_pend_fire ? (NLANES'(1) << pend_lane_q) : w_elig;

    // One-deep pending lane: cleared by cancel or by its grant, overwritten by later sel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q  <= 1'b0;
            pend_lane_q <= '0;
        end else if ((state_q == ST_CREDIT) && cancel_i) begin
            pend_vld_q  <= 1'b0;
        end else if (w_arb_accept) begin
            pend_vld_q  <= 1'b0;
        end else if (((state_q == ST_IDLE) || (state_q == ST_CREDIT))
                     && !w_can_buy && w_sel_hit) begin
            pend_vld_q  <= 1'b1;
            pend_lane_q <= w_sel_low;
        end
    end
`else
    assign w_arb_elig = w_elig;
`endif

    rr_lane_arb #(
        .NLANES (NLANES)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .elig_i   (w_arb_elig),
        .accept_i (w_arb_accept),
        .grant_o  (w_arb_grant),
        .valid_o  (w_arb_valid)
    );

    assign w_coin_val = coin_steps(coin_i);
    assign w_coin_sum = {1'b0, credit_q} + {1'b0, w_coin_val};

    // Next-state, coin acceptance, motor handshake, timeout and payout
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        fault_d      = fault_q;
        motor_go_d   = motor_go_q;
        lane_d       = lane_q;
        to_d         = to_q;
        dispense_d   = 1'b0;
        chg5_d       = 1'b0;
        reject_d     = 1'b0;
        stock_dec    = 1'b0;
        w_arb_accept = 1'b0;

        // Coins are only banked while the machine is taking credit
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (coin_i == COIN_BAD) begin
                    reject_d = 1'b1;
                end else if (coin_i != COIN_NONE) begin
                    if (w_coin_sum > c_credit_max) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = w_coin_sum[CREDIT_W-1:0];
                    end
                end
            end
            default: begin
                reject_d = (coin_i != COIN_NONE);
            end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (credit_d != '0) begin
                    state_d = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (cancel_i) begin
                    state_d = ST_CHANGE;
                end else if (w_arb_valid) begin
                    w_arb_accept = 1'b1;
                    lane_d       = w_arb_grant;
                    motor_go_d   = 1'b1;
                    to_d         = '0;
                    state_d      = ST_VEND;
                end
            end
            ST_VEND: begin
                if (motor_done_i) begin
                    motor_go_d = 1'b0;
                    dispense_d = 1'b1;
                    credit_d   = credit_q - c_price;
                    stock_dec  = 1'b1;
                    state_d    = ST_CHANGE;
                end else if (to_q == c_to_last) begin
                    // Abandon the vend; credit is kept whole for the refund
                    fault_d    = 1'b1;
                    motor_go_d = 1'b0;
                    state_d    = ST_CHANGE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_CHANGE: begin
                if (credit_q != '0) begin
                    chg5_d   = 1'b1;
                    credit_d = credit_q - CREDIT_W'(1);
                end else begin
                    state_d = fault_q ? ST_FAULT : ST_IDLE;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, credit and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            fault_q    <= 1'b0;
            motor_go_q <= 1'b0;
            lane_q     <= '0;
            to_q       <= '0;
            dispense_q <= 1'b0;
            chg5_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            fault_q    <= fault_d;
            motor_go_q <= motor_go_d;
            lane_q     <= lane_d;
            to_q       <= to_d;
            dispense_q <= dispense_d;
            chg5_q     <= chg5_d;
            reject_q   <= reject_d;
        end
    end

    assign motor_go_o    = motor_go_q;
    assign motor_lane_o  = lane_q;
    assign dispense_o    = dispense_q;
    assign chg5_o        = chg5_q;
    assign coin_reject_o = reject_q;
    assign fault_o       = fault_q;
    assign credit_o      = credit_q;
    assign stock_empty_o = ~w_in_stock;
    assign busy_o        = (state_q == ST_VEND) || (state_q == ST_CHANGE)
                           || (state_q == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_vend_lane_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_vend_lane_scheduler                                    |
// | Purpose  : Self-checking bench for vend_lane_scheduler with a        |
// |            transaction-level model of credit, stock and rotation.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_vend_lane_scheduler;

    localparam int N     = 4;
    localparam int PRICE = 4;
    localparam int CMAX  = 7;
    localparam int SINIT = 3;
    localparam int MTO   = 15;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic [1:0]   coin       = 2'b00;
    logic [N-1:0] sel        = '0;
    logic         cancel     = 1'b0;
    logic         motor_done = 1'b0;

    logic         motor_go;
    logic [1:0]   motor_lane;
    logic         dispense;
    logic         chg5;
    logic         coin_reject;
    logic         busy;
    logic         fault;
    logic [N-1:0] stock_empty;
    logic [3:0]   credit;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_credit = 0;
    int m_ptr    = 0;
    int m_lane   = 0;
    int m_stock[N];
    bit m_fault  = 1'b0;

    vend_lane_scheduler #(
        .NLANES     (N),
        .PRICE      (PRICE),
        .CREDIT_MAX (CMAX),
        .STOCK_INIT (SINIT),
        .MOTOR_TO   (MTO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_i        (coin),
        .sel_i         (sel),
        .cancel_i      (cancel),
        .motor_go_o    (motor_go),
        .motor_lane_o  (motor_lane),
        .motor_done_i  (motor_done),
        .dispense_o    (dispense),
        .chg5_o        (chg5),
        .coin_reject_o (coin_reject),
        .busy_o        (busy),
        .fault_o       (fault),
        .stock_empty_o (stock_empty),
        .credit_o      (credit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_ptr    = 0;
        m_fault  = 1'b0;
        for (int i = 0; i < N; i++) m_stock[i] = SINIT;
    endtask

    function automatic logic [N-1:0] exp_empty();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_stock[i] == 0);
        return r;
    endfunction

    task automatic do_reset();
        coin = 2'b00; sel = '0; cancel = 1'b0; motor_done = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic do_coin(input logic [1:0] c);
        int v;
        bit rej;
        v = (c == 2'b01) ? 1 : ((c == 2'b10) ? 2 : 0);
        if (m_fault) rej = (c != 2'b00);
        else         rej = (c == 2'b11) || (v != 0 && m_credit + v > CMAX);
        if (!rej) m_credit += v;
        coin = c;
        tick();
        coin = 2'b00;
        chk("coin_reject", 32'(coin_reject), 32'(rej));
        chk("credit_after_coin", 32'(credit), 32'(m_credit));
    endtask

    task automatic do_sel(input logic [N-1:0] s, input bit c, output int lane);
        lane = -1;
        if (!c && !m_fault && m_credit >= PRICE) begin
            for (int i = 0; i < N; i++) begin
                int l;
                l = (m_ptr + i) % N;
                if (lane < 0 && s[l] && m_stock[l] > 0) lane = l;
            end
        end
        sel = s; cancel = c;
        tick();
        sel = '0; cancel = 1'b0;
        if (lane >= 0) begin
            chk("grant_motor_go", 32'(motor_go), 32'(1));
            chk("grant_lane", 32'(motor_lane), 32'(lane));
            m_ptr  = (lane + 1) % N;
            m_lane = lane;
        end else begin
            chk("nogrant_motor_go", 32'(motor_go), 32'(0));
            chk("nogrant_busy", 32'(busy), 32'(c | m_fault));
        end
    endtask

    task automatic do_motor(input int dly);
        repeat (dly) tick();
        chk("motor_go_held", 32'(motor_go), 32'(1));
        motor_done = 1'b1;
        tick();
        motor_done = 1'b0;
        m_credit -= PRICE;
        m_stock[m_lane]--;
        chk("dispense_pulse", 32'(dispense), 32'(1));
        chk("motor_go_drop", 32'(motor_go), 32'(0));
        chk("credit_after_vend", 32'(credit), 32'(m_credit));
    endtask

    task automatic drain(input bit to_fault);
        int n_chg;
        int n_disp;
        int cycles;
        n_chg = 0; n_disp = 0;
        cycles = m_credit + 2;
        repeat (cycles) begin
            tick();
            if (chg5 === 1'b1) n_chg++;
            if (dispense === 1'b1) n_disp++;
        end
        chk("chg5_count", 32'(n_chg), 32'(m_credit));
        chk("dispense_during_change", 32'(n_disp), 32'(0));
        m_credit = 0;
        chk("busy_after_change", 32'(busy), 32'(to_fault));
        chk("credit_after_change", 32'(credit), 32'(0));
        chk("stock_empty", 32'(stock_empty), 32'(exp_empty()));
    endtask

    initial begin
        int lane;
        int n;
        logic [1:0] c;

        // Reset state
        model_reset();
        tick(); tick();
        chk("rst_motor_go", 32'(motor_go), 32'(0));
        chk("rst_credit", 32'(credit), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_fault", 32'(fault), 32'(0));
        chk("rst_pulses", 32'({dispense, chg5, coin_reject}), 32'(0));
        chk("rst_stock_empty", 32'(stock_empty), 32'(0));
        rst_n = 1'b1;
        tick();

        // Exact price, lane 0
        do_coin(2'b10); do_coin(2'b10);
        do_sel(4'b0001, 1'b0, lane);
        do_motor(3);
        drain(1'b0);

        // Overpay by one step, lane 1
        do_coin(2'b10); do_coin(2'b01); do_coin(2'b10);
        do_sel(4'b0010, 1'b0, lane);
        do_motor(2);
        drain(1'b0);

        // Credit ceiling and invalid coin
        do_coin(2'b10); do_coin(2'b10); do_coin(2'b10); do_coin(2'b10);
        do_sel('0, 1'b1, lane);
        drain(1'b0);
        do_coin(2'b11);

        // Round-robin rotation, then exhaust lane 0
        do_reset();
        repeat (3) begin
            do_coin(2'b10); do_coin(2'b10);
            do_sel(4'b1111, 1'b0, lane);
            do_motor(1);
            drain(1'b0);
        end
        repeat (2) begin
            do_coin(2'b10); do_coin(2'b10);
            do_sel(4'b0001, 1'b0, lane);
            do_motor(0);
            drain(1'b0);
        end
        do_coin(2'b10); do_coin(2'b10);
        do_sel(4'b0001, 1'b0, lane);
        do_sel('0, 1'b1, lane);
        drain(1'b0);

        // Cancel, and cancel colliding with a select
        do_coin(2'b10); do_coin(2'b01);
        do_sel('0, 1'b1, lane);
        drain(1'b0);
        do_coin(2'b10); do_coin(2'b10);
        do_sel(4'b0110, 1'b1, lane);
        drain(1'b0);

        // Randomised sessions
        do_reset();
        repeat (30) begin
            n = 0;
            while (m_credit < PRICE && n < 40) begin
                c = 2'($urandom_range(0, 3));
                do_coin(c);
                n++;
            end
            if ($urandom_range(0, 1) == 1) begin
                c = 2'($urandom_range(0, 3));
                do_coin(c);
            end
            if (m_credit == 0) continue;
            do_sel(N'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), lane);
            if (lane >= 0) begin
                do_motor(int'($urandom_range(0, 8)));
            end else if (busy !== 1'b1) begin
                do_sel('0, 1'b1, lane);
            end
            drain(1'b0);
        end

        // Motor timeout, refund, terminal fault
        do_reset();
        do_coin(2'b10); do_coin(2'b10); do_coin(2'b01);
        do_sel(4'b0010, 1'b0, lane);
        n = 0;
        while (fault !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(MTO));
        chk("timeout_motor_go", 32'(motor_go), 32'(0));
        chk("timeout_credit_kept", 32'(credit), 32'(m_credit));
        drain(1'b1);
        m_fault = 1'b1;
        chk("fault_sticky", 32'(fault), 32'(1));
        do_coin(2'b10);
        do_coin(2'b01);
        do_sel(4'b1111, 1'b0, lane);

        // Asynchronous reset during a vend
        do_reset();
        do_coin(2'b10); do_coin(2'b10);
        do_sel(4'b0001, 1'b0, lane);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_motor_go", 32'(motor_go), 32'(0));
        chk("async_rst_credit", 32'(credit), 32'(0));
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_stock_empty", 32'(stock_empty), 32'(exp_empty()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
